sc_regshifter_ctrl: RTL and testbench

//  Sequencer for the position shift register (P1 shifter): turns start/left/right player requests into
//  one-cycle load/shift commands (load_InLow, shiftselection_In) for the shifter. Enforces per-move cooldown,

---
 rtl/sc_regshifter_ctrl_pkg.sv | 18 +
 rtl/sc_regshifter_ctrl_edge.sv | 30 +++
 rtl/sc_regshifter_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sc_regshifter_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_regshifter_ctrl_pkg.sv
// Shared encodings for the P1 shifter sequencer: FSM states and shifter command codes.
package sc_regshifter_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_COOL  = 3'd4;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_LOAD) || (st == ST_SHIFT) || (st == ST_COOL);
  endfunction

endpackage

// File: rtl/sc_regshifter_ctrl_edge.sv
// Registered rising-edge detector for one synchronized button, with synchronous clear.
module sc_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic level_i,
  output logic pulse_o
);

  logic hist_q;
  logic pulse_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else if (clr_i) begin
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      hist_q  <= level_i;
      pulse_q <= level_i & ~hist_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/sc_regshifter_ctrl.sv
// P1 shifter sequencer: start/left/right requests -> one-cycle load/shift commands with cooldown.
// Optional held-button auto-repeat is enabled by defining SC_REGSHIFTER_CTRL_AUTOREPEAT_EN.
module sc_regshifter_ctrl
  import sc_regshifter_ctrl_pkg::*;
#(
  parameter int                   DATAWIDTH = 8,
  parameter int                   LANES     = 4,
  parameter logic [DATAWIDTH-1:0] INIT_POS  = 8'b00000100,
  parameter int                   COOLDOWN  = 4,
  parameter int                   MOVE_W    = 8,
  parameter int                   REPEAT    = 16
) (
  input  logic                 sc_regshifter_ctrl_CLOCK_50,
  input  logic                 sc_regshifter_ctrl_RESET_InLow,
  input  logic                 sc_regshifter_ctrl_start_InLow,
  input  logic                 sc_regshifter_ctrl_left_In,
  input  logic                 sc_regshifter_ctrl_right_In,
  input  logic [DATAWIDTH-1:0] sc_regshifter_ctrl_position_InBUS,
  output logic                 sc_regshifter_ctrl_load_OutLow,
  output logic [1:0]           sc_regshifter_ctrl_shiftselection_Out,
  output logic [DATAWIDTH-1:0] sc_regshifter_ctrl_data_OutBUS,
  output logic                 sc_regshifter_ctrl_busy_Out,
  output logic                 sc_regshifter_ctrl_blocked_Out,
  output logic [MOVE_W-1:0]    sc_regshifter_ctrl_moves_OutBUS
);

  localparam int CD_W = $clog2(COOLDOWN + 1);

  logic [2:0]           state_q, state_d;
  logic [1:0]           dir_q, dir_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic [MOVE_W-1:0]    moves_q, moves_d;
  logic                 blocked_d;
  logic                 load_q, busy_q, blocked_q;
  logic [1:0]           shsel_q;
  logic [DATAWIDTH-1:0] data_q;

  logic pulse_left, pulse_right;
  logic ev_left, ev_right;
  logic at_left_limit, at_right_limit;

  // Only the two limit lanes are inspected; the rest of the readback is deliberately ignored.
  logic unused_cfg;
  assign unused_cfg = ^{sc_regshifter_ctrl_position_InBUS, (REPEAT > 0)};

  assign at_left_limit  = sc_regshifter_ctrl_position_InBUS[LANES-1];
  assign at_right_limit = sc_regshifter_ctrl_position_InBUS[0];

  sc_edge_detect u_edge_left (
    .clk     (sc_regshifter_ctrl_CLOCK_50),
    .rst_n   (sc_regshifter_ctrl_RESET_InLow),
    .clr_i   (state_q == ST_IDLE),
    .level_i (sc_regshifter_ctrl_left_In),
    .pulse_o (pulse_left)
  );

  sc_edge_detect u_edge_right (
    .clk     (sc_regshifter_ctrl_CLOCK_50),
    .rst_n   (sc_regshifter_ctrl_RESET_InLow),
    .clr_i   (state_q == ST_IDLE),
    .level_i (sc_regshifter_ctrl_right_In),
    .pulse_o (pulse_right)
  );

`ifdef SC_REGSHIFTER_CTRL_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT + 1);

  logic [RP_W-1:0] rep_q;
  logic            armed_q;
  logic            rep_active, rep_evt;

  // The period is measured from the first real edge while the button stays down.
  assign rep_active = (sc_regshifter_ctrl_left_In | sc_regshifter_ctrl_right_In) &&
                      ((state_q == ST_READY) || (state_q == ST_SHIFT) || (state_q == ST_COOL));
  assign rep_evt    = armed_q && rep_active && (rep_q == RP_W'(REPEAT - 1));

  always_ff @(posedge sc_regshifter_ctrl_CLOCK_50 or negedge sc_regshifter_ctrl_RESET_InLow) begin
    if (!sc_regshifter_ctrl_RESET_InLow) begin
      rep_q   <= '0;
      armed_q <= 1'b0;
    end else if (!rep_active) begin
      rep_q   <= '0;
      armed_q <= 1'b0;
    end else if (pulse_left || pulse_right) begin
      rep_q   <= '0;
      armed_q <= 1'b1;
    end else if (rep_evt) begin
      rep_q   <= '0;
    end else if (armed_q) begin
      rep_q   <= rep_q + 1'b1;
    end
  end

  assign ev_left  = pulse_left  | (rep_evt & sc_regshifter_ctrl_left_In);
  assign ev_right = pulse_right | (rep_evt & sc_regshifter_ctrl_right_In);
`else
  assign ev_left  = pulse_left;
  assign ev_right = pulse_right;
`endif

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cd_d      = cd_q;
    moves_d   = moves_q;
    blocked_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sc_regshifter_ctrl_start_InLow) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        moves_d = '0;
        state_d = ST_READY;
      end
      ST_READY: begin
        if (!sc_regshifter_ctrl_start_InLow) begin
          state_d = ST_LOAD;
        end else if (ev_left && ev_right) begin
          blocked_d = 1'b1;
        end else if (ev_left) begin
          if (at_left_limit) begin
            blocked_d = 1'b1;
          end else begin
            dir_d   = SHIFT_LEFT;
            state_d = ST_SHIFT;
          end
        end else if (ev_right) begin
          if (at_right_limit) begin
            blocked_d = 1'b1;
          end else begin
            dir_d   = SHIFT_RIGHT;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        moves_d = (moves_q == '1) ? moves_q : moves_q + 1'b1;
        cd_d    = CD_W'(COOLDOWN - 1);
        state_d = ST_COOL;
      end
      ST_COOL: begin
        if (cd_q == '0) state_d = ST_READY;
        else            cd_d    = cd_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge sc_regshifter_ctrl_CLOCK_50 or negedge sc_regshifter_ctrl_RESET_InLow) begin
    if (!sc_regshifter_ctrl_RESET_InLow) begin
      state_q   <= ST_IDLE;
      dir_q     <= SHIFT_HOLD;
      cd_q      <= '0;
      moves_q   <= '0;
      load_q    <= 1'b1;
      shsel_q   <= SHIFT_HOLD;
      busy_q    <= 1'b0;
      blocked_q <= 1'b0;
      data_q    <= INIT_POS;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cd_q      <= cd_d;
      moves_q   <= moves_d;
      load_q    <= (state_d != ST_LOAD);
      shsel_q   <= (state_d == ST_SHIFT) ? dir_d : SHIFT_HOLD;
      busy_q    <= is_busy(state_d);
      blocked_q <= blocked_d;
      data_q    <= INIT_POS;
    end
  end

  assign sc_regshifter_ctrl_load_OutLow        = load_q;
  assign sc_regshifter_ctrl_shiftselection_Out = shsel_q;
  assign sc_regshifter_ctrl_data_OutBUS        = data_q;
  assign sc_regshifter_ctrl_busy_Out           = busy_q;
  assign sc_regshifter_ctrl_blocked_Out        = blocked_q;
  assign sc_regshifter_ctrl_moves_OutBUS       = moves_q;

endmodule

// File: tb/tb_sc_regshifter_ctrl.sv
// Directed bench for sc_regshifter_ctrl with a behavioural model of the P1 position shifter.
module tb_sc_regshifter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_n, left, right;
  logic [7:0] pos;
  logic       load_n, busy, blocked;
  logic [1:0] shsel;
  logic [7:0] data, moves;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, n_left = 0, n_right = 0, n_blocked = 0, n_load = 0, overlap = 0;
  int right_times[$];

  always #5 clk = ~clk;

  sc_regshifter_ctrl dut (
    .sc_regshifter_ctrl_CLOCK_50           (clk),
    .sc_regshifter_ctrl_RESET_InLow        (rst_n),
    .sc_regshifter_ctrl_start_InLow        (start_n),
    .sc_regshifter_ctrl_left_In            (left),
    .sc_regshifter_ctrl_right_In           (right),
    .sc_regshifter_ctrl_position_InBUS     (pos),
    .sc_regshifter_ctrl_load_OutLow        (load_n),
    .sc_regshifter_ctrl_shiftselection_Out (shsel),
    .sc_regshifter_ctrl_data_OutBUS        (data),
    .sc_regshifter_ctrl_busy_Out           (busy),
    .sc_regshifter_ctrl_blocked_Out        (blocked),
    .sc_regshifter_ctrl_moves_OutBUS       (moves)
  );

  // Shifter model: active-low load, 01 shifts toward MSB, 10 toward LSB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pos <= 8'h00;
    else if (!load_n)       pos <= data;
    else if (shsel == 2'b01) pos <= {pos[6:0], 1'b0};
    else if (shsel == 2'b10) pos <= {1'b0, pos[7:1]};
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (!load_n) n_load = n_load + 1;
      if (!load_n && shsel != 2'b00) overlap = overlap + 1;
      if (shsel == 2'b01) n_left = n_left + 1;
      if (shsel == 2'b10) begin
        n_right = n_right + 1;
        right_times.push_back(cyc);
      end
      if (blocked) n_blocked = n_blocked + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int snap;

  initial begin
    rst_n = 1'b0; start_n = 1'b1; left = 1'b0; right = 1'b0;
    step(2);
    check("rst_load",    load_n,  1);
    check("rst_shsel",   shsel,   0);
    check("rst_data",    data,    8'b00000100);
    check("rst_busy",    busy,    0);
    check("rst_blocked", blocked, 0);
    check("rst_moves",   moves,   0);
    rst_n = 1'b1;
    left = 1'b1;
    step(3);
    left = 1'b0;
    check("idle_ignores_btn", {busy, shsel}, 0);

    // Start pulse: exactly one low cycle on load, shifter takes INIT_POS.
    snap = n_load;
    start_n = 1'b0;
    step();
    check("load_low", load_n, 0);
    check("load_busy", busy, 1);
    start_n = 1'b1;
    step();
    check("load_released", load_n, 1);
    check("load_count", n_load - snap, 1);
    check("pos_init", pos, 8'b00000100);

    // Left from 00000100: two-cycle latency, then cooldown.
    snap = n_left;
    left = 1'b1;
    step();
    check("lat_edge_reg", shsel, 2'b00);
    step();
    check("left_cmd", shsel, 2'b01);
    left = 1'b0;
    step();
    check("left_pos", pos, 8'b00001000);
    check("left_moves", moves, 1);
    check("cool_hold", shsel, 2'b00);
    step(5);
    check("cool_done", busy, 0);
    check("left_cmd_count", n_left - snap, 1);

    // Second left hits the left limit lane.
    left = 1'b1;
    step(2);
    check("limit_blocked", blocked, 1);
    check("limit_shsel", shsel, 2'b00);
    left = 1'b0;
    step();
    check("blocked_one_cycle", blocked, 0);
    check("limit_moves", moves, 1);
    check("limit_no_cmd", n_left - snap, 1);

    // Simultaneous left and right.
    left = 1'b1; right = 1'b1;
    step(2);
    check("conflict_blocked", blocked, 1);
    check("conflict_shsel", shsel, 2'b00);
    check("conflict_moves", moves, 1);
    left = 1'b0; right = 1'b0;
    step(2);

    // Right toggled every cycle: edges in cooldown are dropped, spacing COOLDOWN+2.
    snap = n_blocked;
    right_times.delete();
    for (int i = 0; i < 30; i++) begin
      right = (i % 2 == 0);
      step();
    end
    right = 1'b0;
    step(8);
    check("burst_cmds", right_times.size(), 3);
    if (right_times.size() == 3) begin
      check("burst_gap1", right_times[1] - right_times[0], 6);
      check("burst_gap2", right_times[2] - right_times[1], 6);
    end
    check("burst_pos", pos, 8'b00000001);
    check("burst_moves", moves, 4);
    check("burst_blocked_seen", (n_blocked - snap) > 0, 1);

    // Reload, step left once, then hold right for 40 cycles.
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    step();
    check("reload_moves", moves, 0);
    check("reload_pos", pos, 8'b00000100);
    left = 1'b1;
    step();
    left = 1'b0;
    step(8);
    check("pre_hold_pos", pos, 8'b00001000);
    snap = n_right;
    right = 1'b1;
    step(40);
    right = 1'b0;
    step(10);
`ifdef SC_REGSHIFTER_CTRL_AUTOREPEAT_EN
    check("hold_cmds", n_right - snap, 3);
    check("hold_pos", pos, 8'b00000001);
    check("hold_moves", moves, 4);
`else
    check("hold_cmds", n_right - snap, 1);
    check("hold_pos", pos, 8'b00000100);
    check("hold_moves", moves, 2);
`endif

    // Reset asserted while a shift command is on the bus.
    left = 1'b1;
    step();
    left = 1'b0;
    step();
    check("mid_shift", shsel, 2'b01);
    rst_n = 1'b0;
    #1;
    check("abort_load",  load_n, 1);
    check("abort_shsel", shsel,  0);
    check("abort_moves", moves,  0);
    check("abort_busy",  busy,   0);
    step();
    rst_n = 1'b1;
    step(2);
    check("post_reset_idle", {busy, load_n, shsel}, 4'b0100);
    check("no_load_shift_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

endmodule
